xy_mem_port_arbiter: RTL and testbench
======================================

# xy_mem_port_arbiter

Shares the XY activation memory's read port and write port between the core sequencer and the host loader. The core sequencer drives LOADMAC/MATMUL operand reads and ACCMOV writeback, and always has absolute priority because it cannot stall. Host requests are queued in a small in-order FIFO and are issued only on the cycles the core leaves the relevant port idle. The block sits between the core controller, the host/DMA interface and the dual-port XY memory, which has one read port and one write port.

## Interface
- ADDR_W, 10, XY memory address width (XY_MEM_DEPTH)
- DATA_W, 16, XY memory word width
- FIFO_DEPTH, 4, host request FIFO entries (power of two, ≥2)
- RD_LATENCY, 1, memory read latency in cycles (1..3)
- STARVE_LIMIT, 64, cycles the FIFO head may wait before host_starved is raised

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- core_rd_en  in  1  core reads XY memory this cycle
- core_rd_addr  in  ADDR_W  core read address
- core_wr_en  in  1  core writeback this cycle (xy_write_enable)
- core_wr_addr  in  ADDR_W  core write address
- core_wr_data  in  DATA_W  core write data
- core_rd_data  out  DATA_W  = mem_rd_data, passed through unregistered
- host_req_valid  in  1  host request present
- host_req_ready  out  1  FIFO not full
- host_req_write  in  1  1 = write, 0 = read
- host_req_addr  in  ADDR_W  host address
- host_req_data  in  DATA_W  host write data
- host_rsp_valid  out  1  host read data valid, one pulse per host read
- host_rsp_data  out  DATA_W  host read data
- host_starved  out  1  head request has waited ≥ STARVE_LIMIT cycles
- mem_rd_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  memory read data, RD_LATENCY cycles after address
- mem_wr_en  out  1  memory write enable
- mem_wr_addr  out  ADDR_W  memory write address
- mem_wr_data  out  DATA_W  memory write data

## Operation
- FIFO push: host_req_valid & host_req_ready stores {write, addr, data}. host_req_ready = (count != FIFO_DEPTH). The FIFO has no combinational bypass.
- Issue rule: the head entry issues when its port is free. A read issues when !core_rd_en. A write issues when !core_wr_en. The head pops in the same cycle it issues.
- Ordering is strictly in-order. A blocked head blocks all entries behind it, even if those entries target the other port.
- A push and a pop may occur in the same cycle. When the FIFO is full, a same-cycle pop does NOT raise host_req_ready in that cycle, because ready depends on the registered count.
- Read port mux (combinational): mem_rd_addr = core_rd_en ? core_rd_addr : head.addr. When neither the core nor the host uses the read port, mem_rd_addr holds the head address or 0.
- Write port mux (combinational): mem_wr_en = core_wr_en | host_wr_issue. Address and data come from the core when core_wr_en is set, otherwise from the head.
- Read tag pipeline: a RD_LATENCY-deep shift register of the host_rd_issue bit. host_rsp_valid = tail of the pipeline. host_rsp_data = mem_rd_data.
- The host must accept every response. There is no response backpressure.
- Starvation counter: increments each cycle the FIFO is non-empty and the head does not issue, saturating at STARVE_LIMIT. It clears on issue or when the FIFO is empty. host_starved = (counter == STARVE_LIMIT).
- Core outputs are never delayed or modified by host traffic.

## Timing
- Reset values: FIFO empty, so host_req_ready = 1. host_rsp_valid = 0, starvation counter = 0, host_starved = 0, read tag pipeline all 0. mem_wr_en follows core_wr_en combinationally.
- Minimum host latency: a push at cycle t issues at t+1 at the earliest.
  - Write: the memory write happens at t+1.
  - Read: host_rsp_valid is asserted at t+1+RD_LATENCY.
- Host throughput is one request per cycle while the needed port stays idle.
- Reset asserted mid-operation:
  - FIFO contents and in-flight read tags are discarded immediately.
  - No host_rsp_valid is produced for reads issued before reset.
- A core read and a core write to the same address in the same cycle are passed through unchanged. Read-during-write behaviour is the memory's.
- A host write and a core read to the same address may issue in the same cycle. The result is again the memory's read-during-write behaviour, and the arbiter does not order them.

## Test plan
- Idle core, RD_LATENCY=1:
  - Host writes 0x00AB to address 5 at cycle 0 → mem_wr_en with addr 5 / 0x00AB at cycle 1.
  - Host read of address 5 pushed at cycle 2 → host_rsp_valid with 0x00AB at cycle 4.
- Core priority:
  - Hold core_wr_en high for 10 cycles and push a host write → the host write issues on the first cycle core_wr_en is low.
  - Core writes are unaltered throughout.
- Head-of-line blocking: with core_rd_en held high, push a host read then a host write → the write does not issue until the read issues.
- Full FIFO:
  - Push 4 reads while core_rd_en is high → host_req_ready = 0 after the 4th push.
  - Drop core_rd_en → responses return in push order, and ready returns one cycle after the first pop.
- Starvation: hold core_wr_en high with a queued host write → host_starved rises after 64 waiting cycles and clears the cycle the write issues.
- Reset mid-burst: 3 host reads in flight or queued, assert reset → zero host_rsp_valid pulses afterwards, and host_req_ready = 1 after reset.

Source files
------------

// File: rtl/xy_mem_port_arbiter.sv
// Shares the XY activation memory read/write ports between the core sequencer (absolute priority)
// and an in-order host request FIFO that issues only into idle port cycles.
module xy_mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd_en,
    input  logic [ADDR_W-1:0] core_rd_addr,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_write,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_data,
    output logic              host_rsp_valid,
    output logic [DATA_W-1:0] host_rsp_data,
    output logic              host_starved,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT = STV_W'(STARVE_LIMIT);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                 fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [STV_W-1:0]       starve_cnt;
    logic [RD_LATENCY-1:0]  rd_tag;

    entry_t head;
    logic   empty;
    logic   push;
    logic   host_rd_issue;
    logic   host_wr_issue;
    logic   issue;

    assign head           = fifo[rd_ptr];
    assign empty          = (count == '0);
    assign host_req_ready = (count != FULL);
    assign push           = host_req_valid && host_req_ready;

    // The head only ever takes a port the core leaves idle this cycle.
    assign host_rd_issue  = !empty && !head.write && !core_rd_en;
    assign host_wr_issue  = !empty &&  head.write && !core_wr_en;
    assign issue          = host_rd_issue || host_wr_issue;

    assign mem_rd_addr    = core_rd_en ? core_rd_addr : head.addr;
    assign mem_wr_en      = core_wr_en || host_wr_issue;
    assign mem_wr_addr    = core_wr_en ? core_wr_addr : head.addr;
    assign mem_wr_data    = core_wr_en ? core_wr_data : head.data;

    assign core_rd_data   = mem_rd_data;
    assign host_rsp_data  = mem_rd_data;
    assign host_rsp_valid = rd_tag[RD_LATENCY-1];
    assign host_starved   = (starve_cnt == LIMIT);

    // Entry storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{write: host_req_write, addr: host_req_addr, data: host_req_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (empty || issue) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Read tags track host reads through the memory's read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_tag <= '0;
        end else begin
            rd_tag[0] <= host_rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_tag[i] <= rd_tag[i-1];
            end
        end
    end

endmodule

// File: tb/tb_xy_mem_port_arbiter.sv
// Directed bench for xy_mem_port_arbiter with a behavioural 1-cycle-latency XY memory attached.
module tb_xy_mem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_rd_en;
    logic [ADDR_W-1:0] core_rd_addr;
    logic              core_wr_en;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic [DATA_W-1:0] core_rd_data;
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_write;
    logic [ADDR_W-1:0] host_req_addr;
    logic [DATA_W-1:0] host_req_data;
    logic              host_rsp_valid;
    logic [DATA_W-1:0] host_rsp_data;
    logic              host_starved;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;

    int checks   = 0;
    int failures = 0;

    xy_mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .RD_LATENCY(1), .STARVE_LIMIT(64)
    ) dut (
        .clk(clk), .reset(reset),
        .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_rd_data(core_rd_data),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_write(host_req_write), .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data), .host_starved(host_starved),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    // Memory model: one read port with 1-cycle latency, one write port, read returns old data.
    logic [DATA_W-1:0] xy_mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (mem_wr_en) xy_mem[mem_wr_addr] <= mem_wr_data;
        mem_rd_data <= xy_mem[mem_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_rd_en = 0; core_rd_addr = '0;
        core_wr_en = 0; core_wr_addr = '0; core_wr_data = '0;
        host_req_valid = 0; host_req_write = 0; host_req_addr = '0; host_req_data = '0;
    endtask

    task automatic host_push(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        host_req_valid = 1; host_req_write = wr; host_req_addr = a; host_req_data = d;
    endtask

    typedef struct {
        logic              crd;
        logic [ADDR_W-1:0] crd_a;
        logic              cwr;
        logic [ADDR_W-1:0] cwr_a;
        logic [DATA_W-1:0] cwr_d;
        logic              hv;
        logic              hw;
        logic [ADDR_W-1:0] ha;
        logic [DATA_W-1:0] hd;
        logic              e_wen;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd;
        logic              chk_ra;
        logic [ADDR_W-1:0] e_ra;
        logic              e_rdy;
        logic              e_rsp;
        logic [DATA_W-1:0] e_rsp_d;
    } vec_t;

    vec_t vecs [12];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) xy_mem[i] = '0;
        mem_rd_data = '0;
        idle_inputs();
        reset = 1;
        core_wr_en = 1; core_wr_addr = 10'd11; core_wr_data = 16'h0F0F;
        #2;
        check("reset_ready", host_req_ready, 1);
        check("reset_rsp_valid", host_rsp_valid, 0);
        check("reset_starved", host_starved, 0);
        check("reset_wr_en_follows_core", mem_wr_en, 1);
        core_wr_en = 0;
        #1;
        check("reset_wr_en_follows_core_low", mem_wr_en, 0);
        tick(); tick();
        reset = 0;

        //          crd crd_a cwr cwr_a cwr_d     hv hw ha  hd        wen wa  wd        chkra ra  rdy rsp rsp_d
        vecs[0]  = '{0, 0,    0,  0,    0,        1, 1, 5,  16'h00AB, 0,  0,  0,        0,    0,  1,  0,  0};
        vecs[1]  = '{0, 0,    0,  0,    0,        0, 0, 0,  0,        1,  5,  16'h00AB, 0,    0,  1,  0,  0};
        vecs[2]  = '{0, 0,    0,  0,    0,        1, 0, 5,  0,        0,  0,  0,        0,    0,  1,  0,  0};
        vecs[3]  = '{0, 0,    0,  0,    0,        0, 0, 0,  0,        0,  0,  0,        1,    5,  1,  0,  0};
        vecs[4]  = '{0, 0,    0,  0,    0,        0, 0, 0,  0,        0,  0,  0,        0,    0,  1,  1,  16'h00AB};
        vecs[5]  = '{1, 9,    1,  7,    16'h1234, 1, 1, 3,  16'h0055, 1,  7,  16'h1234, 1,    9,  1,  0,  0};
        vecs[6]  = '{0, 0,    1,  8,    16'h4321, 1, 0, 7,  0,        1,  8,  16'h4321, 0,    0,  1,  0,  0};
        vecs[7]  = '{1, 2,    0,  0,    0,        0, 0, 0,  0,        1,  3,  16'h0055, 1,    2,  1,  0,  0};
        vecs[8]  = '{1, 4,    0,  0,    0,        0, 0, 0,  0,        0,  0,  0,        1,    4,  1,  0,  0};
        vecs[9]  = '{0, 0,    0,  0,    0,        0, 0, 0,  0,        0,  0,  0,        1,    7,  1,  0,  0};
        vecs[10] = '{0, 0,    0,  0,    0,        0, 0, 0,  0,        0,  0,  0,        0,    0,  1,  1,  16'h1234};
        vecs[11] = '{0, 0,    0,  0,    0,        0, 0, 0,  0,        0,  0,  0,        0,    0,  1,  0,  0};

        for (int i = 0; i < 12; i++) begin
            tick();
            core_rd_en = vecs[i].crd; core_rd_addr = vecs[i].crd_a;
            core_wr_en = vecs[i].cwr; core_wr_addr = vecs[i].cwr_a; core_wr_data = vecs[i].cwr_d;
            host_req_valid = vecs[i].hv; host_req_write = vecs[i].hw;
            host_req_addr = vecs[i].ha; host_req_data = vecs[i].hd;
            #1;
            check($sformatf("vec%0d_wr_en", i), mem_wr_en, vecs[i].e_wen);
            if (vecs[i].e_wen) begin
                check($sformatf("vec%0d_wr_addr", i), mem_wr_addr, vecs[i].e_wa);
                check($sformatf("vec%0d_wr_data", i), mem_wr_data, vecs[i].e_wd);
            end
            if (vecs[i].chk_ra) check($sformatf("vec%0d_rd_addr", i), mem_rd_addr, vecs[i].e_ra);
            check($sformatf("vec%0d_ready", i), host_req_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_rsp_valid", i), host_rsp_valid, vecs[i].e_rsp);
            if (vecs[i].e_rsp) begin
                check($sformatf("vec%0d_rsp_data", i), host_rsp_data, vecs[i].e_rsp_d);
                check($sformatf("vec%0d_core_rd_data", i), core_rd_data, vecs[i].e_rsp_d);
            end
        end

        // Core write priority and starvation: core writes 70 cycles, host write waits behind it.
        for (int k = 0; k < 72; k++) begin
            tick();
            idle_inputs();
            if (k == 0) host_push(1, 10'd30, 16'hBEEF);
            if (k < 70) begin
                core_wr_en = 1; core_wr_addr = ADDR_W'(20 + k); core_wr_data = DATA_W'(16'h0100 + k);
            end
            #1;
            if (k < 70) begin
                check("prio_core_wr_addr", mem_wr_addr, 32'(20 + k));
                check("prio_core_wr_data", mem_wr_data, 32'(16'h0100 + k));
            end
            if (k == 64) check("starved_before_limit", host_starved, 0);
            if (k == 65) check("starved_at_limit", host_starved, 1);
            if (k == 69) check("starved_held", host_starved, 1);
            if (k == 70) begin
                check("prio_host_wr_en", mem_wr_en, 1);
                check("prio_host_wr_addr", mem_wr_addr, 30);
                check("prio_host_wr_data", mem_wr_data, 16'hBEEF);
            end
            if (k == 71) begin
                check("starved_cleared", host_starved, 0);
                check("prio_idle_wr_en", mem_wr_en, 0);
            end
        end

        // Full FIFO: four reads queued behind core reads, a fifth push refused.
        for (int k = 0; k < 11; k++) begin
            tick();
            idle_inputs();
            if (k <= 4) begin
                core_rd_en = 1; core_rd_addr = 10'd0;
            end
            case (k)
                0: host_push(0, 10'd5, 0);
                1: host_push(0, 10'd7, 0);
                2: host_push(0, 10'd3, 0);
                3: host_push(0, 10'd30, 0);
                4: host_push(0, 10'd5, 0);
                default: ;
            endcase
            #1;
            if (k <= 3) check("full_ready_before", host_req_ready, 1);
            if (k == 4) check("full_ready_low", host_req_ready, 0);
            if (k == 5) begin
                check("full_ready_low_on_pop", host_req_ready, 0);
                check("full_rd_addr0", mem_rd_addr, 5);
            end
            if (k == 6) begin
                check("full_ready_back", host_req_ready, 1);
                check("full_rd_addr1", mem_rd_addr, 7);
                check("full_rsp0_valid", host_rsp_valid, 1);
                check("full_rsp0_data", host_rsp_data, 16'h00AB);
            end
            if (k == 7) begin
                check("full_rd_addr2", mem_rd_addr, 3);
                check("full_rsp1_valid", host_rsp_valid, 1);
                check("full_rsp1_data", host_rsp_data, 16'h1234);
            end
            if (k == 8) begin
                check("full_rd_addr3", mem_rd_addr, 30);
                check("full_rsp2_valid", host_rsp_valid, 1);
                check("full_rsp2_data", host_rsp_data, 16'h0055);
            end
            if (k == 9) begin
                check("full_rsp3_valid", host_rsp_valid, 1);
                check("full_rsp3_data", host_rsp_data, 16'hBEEF);
            end
            if (k == 10) check("full_no_extra_rsp", host_rsp_valid, 0);
        end

        // Head-of-line blocking: a write queued behind a blocked read must wait.
        for (int k = 0; k < 6; k++) begin
            tick();
            idle_inputs();
            if (k <= 3) core_rd_en = 1;
            if (k == 0) host_push(0, 10'd5, 0);
            if (k == 1) host_push(1, 10'd40, 16'h0777);
            #1;
            if (k >= 1 && k <= 3) check("hol_write_blocked", mem_wr_en, 0);
            if (k == 4) begin
                check("hol_read_issue_addr", mem_rd_addr, 5);
                check("hol_write_still_blocked", mem_wr_en, 0);
            end
            if (k == 5) begin
                check("hol_write_issue_en", mem_wr_en, 1);
                check("hol_write_issue_addr", mem_wr_addr, 40);
                check("hol_write_issue_data", mem_wr_data, 16'h0777);
                check("hol_rsp_data", host_rsp_data, 16'h00AB);
                check("hol_rsp_valid", host_rsp_valid, 1);
            end
        end

        // Reset mid-burst: one read in flight, two queued.
        for (int k = 0; k < 5; k++) begin
            tick();
            idle_inputs();
            if (k <= 2) core_rd_en = 1;
            if (k == 0) host_push(0, 10'd5, 0);
            if (k == 1) host_push(0, 10'd7, 0);
            if (k == 2) host_push(0, 10'd3, 0);
            #1;
            if (k == 4) check("rst_pre_rsp_valid", host_rsp_valid, 1);
        end
        #1;
        reset = 1;
        #1;
        check("rst_async_rsp_valid", host_rsp_valid, 0);
        check("rst_async_ready", host_req_ready, 1);
        tick(); tick();
        reset = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            idle_inputs();
            #1;
            check("rst_after_rsp_valid", host_rsp_valid, 0);
            check("rst_after_ready", host_req_ready, 1);
            check("rst_after_wr_en", mem_wr_en, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
